// File: rtl/hood_mode_fsm_pkg.sv
// Shared definitions for the range-hood mode controller and the mode LED decoder.
// Holds the state code constants and a helper that classifies the timed states.
package hood_mode_fsm_pkg;

  typedef enum logic [2:0] {
    ST_OFF             = 3'b000,
    ST_STANDBY         = 3'b001,
    ST_MODE_SELECT     = 3'b010,
    ST_FIRST_LEVEL     = 3'b011,
    ST_SECOND_LEVEL    = 3'b100,
    ST_THIRD_LEVEL     = 3'b101,
    ST_SELF_CLEAN      = 3'b110,
    ST_WAIT_TO_STANDBY = 3'b111
  } hood_state_e;

  // The countdown carries a meaningful value only in these states.
  function automatic logic is_timed(hood_state_e s);
    return (s == ST_THIRD_LEVEL) || (s == ST_SELF_CLEAN) || (s == ST_WAIT_TO_STANDBY);
  endfunction

endpackage

// File: rtl/hood_mode_fsm_sec_countdown.sv
// Seconds countdown: clear beats load beats tick, and the count saturates at zero.
// expire flags the tick that takes the count from 1 to 0.
module sec_countdown #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/hood_mode_fsm.sv
// Range-hood mode controller: power/menu/level/clean buttons select the fan mode,
// with timed third level, wait-to-standby and self-clean phases.
module hood_mode_fsm
  import hood_mode_fsm_pkg::*;
#(
  parameter int unsigned HURRICANE_SEC = 60,
  parameter int unsigned CLEAN_SEC     = 180,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             btn_power,
  input  logic             btn_menu,
  input  logic             btn_l1,
  input  logic             btn_l2,
  input  logic             btn_l3,
  input  logic             btn_clean,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] countdown,
  output logic             hurricane_used,
  output logic             clean_done
);

  localparam logic [CNT_W-1:0] HURRICANE_LOAD = CNT_W'(HURRICANE_SEC);
  localparam logic [CNT_W-1:0] CLEAN_LOAD     = CNT_W'(CLEAN_SEC);

  hood_state_e      state_q, state_d;
  logic             hurricane_used_q, hurricane_used_d;
  logic             clean_done_q, clean_done_d;
  logic             cnt_load, cnt_clear, cnt_expire;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    clean_done_d = 1'b0;

    // Power is checked first in every arm so that it overrides any coincident tick.
    case (state_q)
      ST_OFF: begin
        if (btn_power) state_d = ST_STANDBY;
      end
      ST_STANDBY: begin
        if (btn_power)     state_d = ST_OFF;
        else if (btn_menu) state_d = ST_MODE_SELECT;
      end
      ST_MODE_SELECT: begin
        if (btn_power)     state_d = ST_OFF;
        else if (btn_menu) state_d = ST_STANDBY;
        else if (btn_l1)   state_d = ST_FIRST_LEVEL;
        else if (btn_l2)   state_d = ST_SECOND_LEVEL;
        else if (btn_l3) begin
          // A refused l3 still consumes the cycle: clean is not looked at.
          if (!hurricane_used_q) begin
            state_d      = ST_THIRD_LEVEL;
            cnt_load     = 1'b1;
            cnt_load_val = HURRICANE_LOAD;
          end
        end else if (btn_clean) begin
          state_d      = ST_SELF_CLEAN;
          cnt_load     = 1'b1;
          cnt_load_val = CLEAN_LOAD;
        end
      end
      ST_FIRST_LEVEL, ST_SECOND_LEVEL: begin
        if (btn_power)     state_d = ST_OFF;
        else if (btn_menu) state_d = ST_STANDBY;
        else if (btn_l1)   state_d = ST_FIRST_LEVEL;
        else if (btn_l2)   state_d = ST_SECOND_LEVEL;
      end
      ST_THIRD_LEVEL: begin
        if (btn_power) begin
          state_d = ST_OFF;
        end else if (btn_menu) begin
          state_d      = ST_WAIT_TO_STANDBY;
          cnt_load     = 1'b1;
          cnt_load_val = HURRICANE_LOAD;
        end else if (cnt_expire) begin
          state_d = ST_SECOND_LEVEL;
        end
      end
      ST_WAIT_TO_STANDBY: begin
        if (btn_power)       state_d = ST_OFF;
        else if (cnt_expire) state_d = ST_STANDBY;
      end
      ST_SELF_CLEAN: begin
        if (btn_power) begin
          state_d = ST_OFF;
        end else if (cnt_expire) begin
          state_d      = ST_STANDBY;
          clean_done_d = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    cnt_clear        = !is_timed(state_d);
    hurricane_used_d = hurricane_used_q;
    if (state_d == ST_OFF) begin
      hurricane_used_d = 1'b0;
    end else if ((state_d == ST_THIRD_LEVEL) && (state_q != ST_THIRD_LEVEL)) begin
      hurricane_used_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_OFF;
      hurricane_used_q <= 1'b0;
      clean_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      hurricane_used_q <= hurricane_used_d;
      clean_done_q     <= clean_done_d;
    end
  end

  sec_countdown #(
    .CNT_W (CNT_W)
  ) u_sec_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (tick_1s),
    .clear    (cnt_clear),
    .count    (cnt_value),
    .expire   (cnt_expire)
  );

  assign state          = state_q;
  assign countdown      = cnt_value;
  assign hurricane_used = hurricane_used_q;
  assign clean_done     = clean_done_q;

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Scoreboard bench for hood_mode_fsm with short timers (HURRICANE_SEC=3, CLEAN_SEC=5).
module tb_hood_mode_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1s, btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean;
  logic [2:0] state;
  logic [7:0] countdown;
  logic       hurricane_used, clean_done;

  hood_mode_fsm #(
    .HURRICANE_SEC (3),
    .CLEAN_SEC     (5),
    .CNT_W         (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_1s        (tick_1s),
    .btn_power      (btn_power),
    .btn_menu       (btn_menu),
    .btn_l1         (btn_l1),
    .btn_l2         (btn_l2),
    .btn_l3         (btn_l3),
    .btn_clean      (btn_clean),
    .state          (state),
    .countdown      (countdown),
    .hurricane_used (hurricane_used),
    .clean_done     (clean_done)
  );

  always #5 clk = ~clk;

  // Input vector order: power, menu, l1, l2, l3, clean, tick
  localparam logic [6:0] N = 7'b0000000;
  localparam logic [6:0] P = 7'b1000000;
  localparam logic [6:0] M = 7'b0100000;
  localparam logic [6:0] A = 7'b0010000;
  localparam logic [6:0] B = 7'b0001000;
  localparam logic [6:0] H = 7'b0000100;
  localparam logic [6:0] C = 7'b0000010;
  localparam logic [6:0] T = 7'b0000001;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [7:0] cd;
    logic       hu;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] b, input logic [2:0] st,
                     input logic [7:0] cd, input logic hu, input logic dn);
    exp_t e;
    @(negedge clk);
    {btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, tick_1s} = b;
    e.tag = tag; e.st = st; e.cd = cd; e.hu = hu; e.dn = dn;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".state"}, 32'(state), 32'(e.st));
      check({e.tag, ".countdown"}, 32'(countdown), 32'(e.cd));
      check({e.tag, ".hurricane_used"}, 32'(hurricane_used), 32'(e.hu));
      check({e.tag, ".clean_done"}, 32'(clean_done), 32'(e.dn));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    {btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, tick_1s} = P | T;
    #12;
    check("reset.state", 32'(state), 32'd0);
    check("reset.countdown", 32'(countdown), 32'd0);
    check("reset.hurricane_used", 32'(hurricane_used), 32'd0);
    check("reset.clean_done", 32'(clean_done), 32'd0);
    @(negedge clk);
    {btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, tick_1s} = N;
    rst_n = 1'b1;

    // Basic navigation
    cyc("idle_off",     N,     3'd0, 8'd0, 1'b0, 1'b0);
    cyc("power_on",     P,     3'd1, 8'd0, 1'b0, 1'b0);
    cyc("sb_ignore",    A | T, 3'd1, 8'd0, 1'b0, 1'b0);
    cyc("menu",         M,     3'd2, 8'd0, 1'b0, 1'b0);
    cyc("l1",           A,     3'd3, 8'd0, 1'b0, 1'b0);
    cyc("l2",           B,     3'd4, 8'd0, 1'b0, 1'b0);
    cyc("lvl_ignore",   H | C, 3'd4, 8'd0, 1'b0, 1'b0);
    cyc("menu_sb",      M,     3'd1, 8'd0, 1'b0, 1'b0);

    // Third level runs out into second level
    cyc("ms",           M,     3'd2, 8'd0, 1'b0, 1'b0);
    cyc("l3_enter",     H,     3'd5, 8'd3, 1'b1, 1'b0);
    cyc("l3_t1",        T | A, 3'd5, 8'd2, 1'b1, 1'b0);
    cyc("l3_t2",        T,     3'd5, 8'd1, 1'b1, 1'b0);
    cyc("l3_expire",    T,     3'd4, 8'd0, 1'b1, 1'b0);
    cyc("l2_menu",      M,     3'd1, 8'd0, 1'b1, 1'b0);
    cyc("ms2",          M,     3'd2, 8'd0, 1'b1, 1'b0);
    cyc("l3_blocked",   H | C, 3'd2, 8'd0, 1'b1, 1'b0);
    cyc("l3_blocked2",  H,     3'd2, 8'd0, 1'b1, 1'b0);

    // Power cycle clears hurricane_used; wait-to-standby path
    cyc("off",          P,     3'd0, 8'd0, 1'b0, 1'b0);
    cyc("on",           P,     3'd1, 8'd0, 1'b0, 1'b0);
    cyc("ms3",          M,     3'd2, 8'd0, 1'b0, 1'b0);
    cyc("l3_again",     H,     3'd5, 8'd3, 1'b1, 1'b0);
    cyc("l3_dec",       T,     3'd5, 8'd2, 1'b1, 1'b0);
    cyc("wait_load",    M | T, 3'd7, 8'd3, 1'b1, 1'b0);
    cyc("wait_t1",      T,     3'd7, 8'd2, 1'b1, 1'b0);
    cyc("wait_l1",      A,     3'd7, 8'd2, 1'b1, 1'b0);
    cyc("wait_clean_t", C | T, 3'd7, 8'd1, 1'b1, 1'b0);
    cyc("wait_expire",  T,     3'd1, 8'd0, 1'b1, 1'b0);

    // Priority: l1 over l2, menu over l1
    cyc("ms4",          M,     3'd2, 8'd0, 1'b1, 1'b0);
    cyc("prio_l1_l2",   A | B, 3'd3, 8'd0, 1'b1, 1'b0);
    cyc("prio_menu_l1", M | A, 3'd1, 8'd0, 1'b1, 1'b0);

    // Self-clean completes with a single clean_done pulse
    cyc("ms5",          M,     3'd2, 8'd0, 1'b1, 1'b0);
    cyc("clean_enter",  C,     3'd6, 8'd5, 1'b1, 1'b0);
    cyc("clean_t1",     T,     3'd6, 8'd4, 1'b1, 1'b0);
    cyc("clean_ign",    A | M, 3'd6, 8'd4, 1'b1, 1'b0);
    cyc("clean_t2",     T,     3'd6, 8'd3, 1'b1, 1'b0);
    cyc("clean_t3",     T,     3'd6, 8'd2, 1'b1, 1'b0);
    cyc("clean_t4",     T,     3'd6, 8'd1, 1'b1, 1'b0);
    cyc("clean_done",   T,     3'd1, 8'd0, 1'b1, 1'b1);
    cyc("clean_pulse",  N,     3'd1, 8'd0, 1'b1, 1'b0);
    cyc("sb_tick",      T,     3'd1, 8'd0, 1'b1, 1'b0);

    // Power with tick mid-clean, then power with tick on the expiring second
    cyc("ms6",          M,     3'd2, 8'd0, 1'b1, 1'b0);
    cyc("clean2",       C,     3'd6, 8'd5, 1'b1, 1'b0);
    cyc("clean2_t",     T,     3'd6, 8'd4, 1'b1, 1'b0);
    cyc("pwr_tick",     P | T, 3'd0, 8'd0, 1'b0, 1'b0);
    cyc("off_idle",     T,     3'd0, 8'd0, 1'b0, 1'b0);
    cyc("on2",          P,     3'd1, 8'd0, 1'b0, 1'b0);
    cyc("ms7",          M,     3'd2, 8'd0, 1'b0, 1'b0);
    cyc("clean3",       C,     3'd6, 8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("clean3_t",   T,     3'd6, 8'(4 - i), 1'b0, 1'b0);
    cyc("pwr_expire",   P | T, 3'd0, 8'd0, 1'b0, 1'b0);
    cyc("no_done",      N,     3'd0, 8'd0, 1'b0, 1'b0);

    // Asynchronous reset during wait-to-standby
    cyc("on3",          P,     3'd1, 8'd0, 1'b0, 1'b0);
    cyc("ms8",          M,     3'd2, 8'd0, 1'b0, 1'b0);
    cyc("l3_3",         H,     3'd5, 8'd3, 1'b1, 1'b0);
    cyc("wait2",        M,     3'd7, 8'd3, 1'b1, 1'b0);
    cyc("wait2_t",      T,     3'd7, 8'd2, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.state", 32'(state), 32'd0);
    check("async.countdown", 32'(countdown), 32'd0);
    check("async.hurricane_used", 32'(hurricane_used), 32'd0);
    check("async.clean_done", 32'(clean_done), 32'd0);
    @(negedge clk);
    {btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, tick_1s} = N;
    rst_n = 1'b1;
    cyc("post_reset",   T,     3'd0, 8'd0, 1'b0, 1'b0);
    cyc("post_on",      P,     3'd1, 8'd0, 1'b0, 1'b0);

    @(negedge clk);
    {btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, tick_1s} = N;
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hood_mode_fsm.md
HOOD_MODE_FSM -- requirements
Module: hood_mode_fsm

Interface
REQ-001 Parameter HURRICANE_SEC, default 60, SHALL set the third-level run time and the wait-to-standby time in seconds.
REQ-002 Parameter CLEAN_SEC, default 180, SHALL set the self-clean run time in seconds.
REQ-003 Parameter CNT_W, default 8, SHALL set the countdown width; both time parameters SHALL fit in CNT_W bits.
REQ-004 Clock and reset SHALL be one clock and an asynchronous, active-low reset: clk input 1 = system clock, all state on rising edge; rst_n input 1 = reset, asynchronous, active-low.
REQ-005 tick_1s  input  1  one-cycle pulse, once per second.
REQ-006 btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean  input  1 each  debounced single-cycle press pulses.
REQ-007 state  output  3  current mode code, drives the mode LED decoder.
REQ-008 countdown  output  CNT_W  seconds remaining in the timed states, 0 otherwise.
REQ-009 hurricane_used  output  1  third level has been used since power-on.
REQ-010 clean_done  output  1  one-cycle pulse when self-clean completes.

Function
REQ-011 State codes SHALL be OFF=000, STANDBY=001, MODE_SELECT=010, FIRST_LEVEL=011, SECOND_LEVEL=100, THIRD_LEVEL=101, SELF_CLEAN=110, WAIT_TO_STANDBY=111.
REQ-012 Button priority within a cycle SHALL be power > menu > l1 > l2 > l3 > clean; only the highest-priority asserted button acts.
REQ-013 btn_power SHALL move OFF to STANDBY; in any other state it SHALL move to OFF, clear countdown and clear hurricane_used.
REQ-014 STANDBY: btn_menu goes to MODE_SELECT; all other buttons except power are ignored.
REQ-015 MODE_SELECT: l1 goes to FIRST_LEVEL, l2 to SECOND_LEVEL, clean to SELF_CLEAN, menu to STANDBY. l3 goes to THIRD_LEVEL only if hurricane_used=0; otherwise it is ignored and lower-priority buttons in the same cycle do not act.
REQ-016 FIRST/SECOND_LEVEL: l1/l2 switch between these two levels; menu goes to STANDBY immediately; l3 and clean are ignored.
REQ-017 On entry to THIRD_LEVEL, countdown SHALL load HURRICANE_SEC and hurricane_used SHALL set, both on the transition edge.
REQ-018 THIRD_LEVEL: each tick decrements countdown. A tick at countdown=1 SHALL set countdown to 0 and enter SECOND_LEVEL on the same edge. btn_menu SHALL enter WAIT_TO_STANDBY and reload HURRICANE_SEC. Level and clean buttons are ignored.
REQ-019 WAIT_TO_STANDBY: each tick decrements countdown. A tick at countdown=1 SHALL enter STANDBY with countdown 0. All buttons except power are ignored.
REQ-020 SELF_CLEAN: entry loads CLEAN_SEC. Each tick decrements countdown. A tick at countdown=1 SHALL enter STANDBY and assert clean_done for exactly one cycle. All buttons except power are ignored.
REQ-021 A tick coincident with a countdown load SHALL be ignored, so the load value wins. A tick coincident with btn_power SHALL be ignored, so OFF wins.
REQ-022 countdown SHALL read 0 in all untimed states and SHALL never wrap below 0.
REQ-023 Outputs SHALL be registered; a state change is visible one cycle after the causing button pulse.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=OFF, countdown=0, hurricane_used=0 and clean_done=0, regardless of clk.
REQ-025 Reset asserted mid-countdown SHALL abort the countdown with no clean_done pulse; after release the block SHALL be in OFF.

Structure
REQ-026 State code constants SHALL live in shared header hood_defs, included by this block and by the mode LED decoder.
REQ-027 Countdown load/decrement/zero-detect SHALL be sub-module sec_countdown (inputs load, load_val, tick, clear; outputs count, expire).
REQ-028 The implementation SHALL contain no latches; the next-state logic SHALL be a single case with a default that goes to OFF.

Verification (parameters HURRICANE_SEC=3, CLEAN_SEC=5 for speed)
REQ-029 Reset, then power, menu, l1, l2, menu -> state 000, 001, 010, 011, 100, 001; countdown stays 0.
REQ-030 From MODE_SELECT press l3 -> 101, countdown=3, hurricane_used=1; after 3 ticks -> 100, countdown 0. Return to MODE_SELECT and press l3 -> state stays 010.
REQ-031 In THIRD_LEVEL with countdown=2, press menu -> 111 with countdown=3; after 3 ticks -> 001. Buttons l1 and clean during the wait -> no effect.
REQ-032 From MODE_SELECT press clean -> 110, countdown=5; after 5 ticks -> 001 with clean_done high for exactly 1 cycle.
REQ-033 Power and tick in the same cycle during SELF_CLEAN -> 000, countdown 0, no clean_done pulse. Power again -> 001 with hurricane_used=0.
REQ-034 Assert rst_n=0 asynchronously mid-WAIT_TO_STANDBY -> outputs are 000/0/0/0 before the next clk edge.
